// File: rtl/arith_chain_pipe.sv
// rtl/arith_chain_pipe.sv - three-stage valid/ready x -> (x+K, x*(x+K)) pipeline with forwarded mode
// Outputs come straight from stage 3 registers; only in_ready is combinational.
module arith_chain_pipe #(
  parameter int W = 8,
  parameter int K = 13
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_z,
  output logic         out_ovf
);

  localparam logic [W-1:0] KM = W'(K);

  logic           v1, v2, v3;
  logic [W-1:0]   x1;
  logic [W-1:0]   x2, y2;
  logic           c2;
  logic [W-1:0]   x3, y3, z3;
  logic           ovf3;
  logic           mode_q;

  logic           eff_mode;
  logic           ld1, ld2, ld3;
  logic           in_fire;
  logic [W:0]     sum2;
  logic [2*W-1:0] prod3;
  logic [W:0]     sum_f;
  logic [2*W-1:0] prod_f;

  // A mode request only takes effect on an empty pipeline, so results never reorder.
  assign eff_mode = (v1 || v2 || v3) ? mode_q : mode;

  assign ld3 = !v3 || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;

  assign in_ready = RST_N && (eff_mode ? ld3 : ld1);
  assign in_fire  = in_valid && in_ready;

  assign sum2  = {1'b0, x1} + {1'b0, KM};
  assign prod3 = (2*W)'(x2) * (2*W)'(y2);

  assign sum_f  = {1'b0, in_data} + {1'b0, KM};
  assign prod_f = (2*W)'(in_data) * (2*W)'(sum_f[W-1:0]);

  assign out_valid = v3;
  assign out_x     = x3;
  assign out_y     = y3;
  assign out_z     = z3;
  assign out_ovf   = ovf3;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      x1     <= '0;
      x2     <= '0;
      y2     <= '0;
      c2     <= 1'b0;
      x3     <= '0;
      y3     <= '0;
      z3     <= '0;
      ovf3   <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      mode_q <= eff_mode;
      if (eff_mode) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        if (ld3) begin
          v3 <= in_fire;
          if (in_fire) begin
            x3   <= in_data;
            y3   <= sum_f[W-1:0];
            z3   <= prod_f[W-1:0];
            ovf3 <= sum_f[W] | (|prod_f[2*W-1:W]);
          end
        end
      end else begin
        if (ld3) begin
          v3 <= v2;
          if (v2) begin
            x3   <= x2;
            y3   <= y2;
            z3   <= prod3[W-1:0];
            ovf3 <= c2 | (|prod3[2*W-1:W]);
          end
        end
        if (ld2) begin
          v2 <= v1;
          if (v1) begin
            x2 <= x1;
            y2 <= sum2[W-1:0];
            c2 <= sum2[W];
          end
        end
        if (ld1) begin
          v1 <= in_fire;
          if (in_fire) begin
            x1 <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arith_chain_pipe.sv
// tb/tb_arith_chain_pipe.sv - directed and randomized checks of arith_chain_pipe at W=8 and W=12
// Results are packed as {ovf, z, y, x} in 16-bit fields for comparison.
module tb_arith_chain_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        mode;
  logic        in_valid;
  logic        out_ready;

  logic [7:0]  in_data8;
  logic        in_ready8, out_valid8, out_ovf8;
  logic [7:0]  out_x8, out_y8, out_z8;

  logic [11:0] in_data12;
  logic        in_ready12, out_valid12, out_ovf12;
  logic [11:0] out_x12, out_y12, out_z12;

  int checks   = 0;
  int failures = 0;

  logic [63:0] q8[$];
  logic [63:0] q12[$];
  logic        prev_stall8;
  logic [63:0] prev_obs8;
  int          acc;

  logic [7:0] vx[4] = '{8'h19, 8'h0A, 8'hFA, 8'h00};
  logic [7:0] vy[4] = '{8'h26, 8'h17, 8'h07, 8'h0D};
  logic [7:0] vz[4] = '{8'hB6, 8'hE6, 8'hD6, 8'h00};
  logic       vo[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  arith_chain_pipe #(.W(8), .K(13)) u8 (
    .CLK(CLK), .RST_N(RST_N), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_x(out_x8), .out_y(out_y8), .out_z(out_z8), .out_ovf(out_ovf8)
  );

  arith_chain_pipe #(.W(12), .K(13)) u12 (
    .CLK(CLK), .RST_N(RST_N), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready12), .in_data(in_data12),
    .out_valid(out_valid12), .out_ready(out_ready),
    .out_x(out_x12), .out_y(out_y12), .out_z(out_z12), .out_ovf(out_ovf12)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z, input logic o);
    return {15'b0, o, z, y, x};
  endfunction

  function automatic logic [63:0] model(input int w, input longint x);
    longint m, s, y, p;
    m = longint'(1) << w;
    s = x + 13;
    y = s % m;
    p = x * y;
    return pack(16'(x), 16'(y), 16'(p % m), (s >= m) || (p >= m));
  endfunction

  function automatic logic [63:0] obs8();
    return pack({8'b0, out_x8}, {8'b0, out_y8}, {8'b0, out_z8}, out_ovf8);
  endfunction

  function automatic logic [63:0] obs12();
    return pack({4'b0, out_x12}, {4'b0, out_y12}, {4'b0, out_z12}, out_ovf12);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic sb_step();
    if (prev_stall8) begin
      chk("rnd8_hold_v", out_valid8, 1);
      chk("rnd8_hold", obs8(), prev_obs8);
    end
    if (out_valid8 && out_ready) begin
      if (q8.size() == 0) chk("rnd8_unexpected", out_valid8, 0);
      else chk("rnd8_data", obs8(), q8.pop_front());
    end
    if (out_valid12 && out_ready) begin
      if (q12.size() == 0) chk("rnd12_unexpected", out_valid12, 0);
      else chk("rnd12_data", obs12(), q12.pop_front());
    end
    prev_stall8 = out_valid8 && !out_ready;
    prev_obs8   = obs8();
    if (in_valid && in_ready8)  q8.push_back(model(8, longint'(in_data8)));
    if (in_valid && in_ready12) q12.push_back(model(12, longint'(in_data12)));
  endtask

  initial begin
    RST_N = 1'b0; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_data8 = 8'h55; in_data12 = 12'h0;
    tick();
    #1;
    chk("rst_in_ready", in_ready8, 0);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_data", obs8(), 0);

    RST_N = 1'b1; in_valid = 1'b0;
    tick();

    // pipelined: four back-to-back operands, results from the third edge on
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data8 = (i < 4) ? vx[i] : 8'h00;
      #1;
      if (i < 4) chk("pipe_in_ready", in_ready8, 1);
      tick();
      #1;
      if (i < 2) chk("pipe_latency", out_valid8, 0);
      else begin
        chk("pipe_valid", out_valid8, 1);
        chk("pipe_data", obs8(), pack({8'b0, vx[i-2]}, {8'b0, vy[i-2]}, {8'b0, vz[i-2]}, vo[i-2]));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("pipe_drained", out_valid8, 0);

    // backpressure: five operands against a stalled sink
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 5);
      in_data8 = 8'(8'h30 + acc);
      #1;
      chk("bp_in_ready", in_ready8, (c < 3));
      if (c >= 3) begin
        chk("bp_hold_v", out_valid8, 1);
        chk("bp_hold", obs8(), model(8, 'h30));
      end
      if (in_valid && in_ready8) acc++;
      tick();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      in_valid = (acc < 5);
      in_data8 = 8'(8'h30 + acc);
      #1;
      if (r == 0) chk("full_release_in_ready", in_ready8, 1);
      chk("flow_valid", out_valid8, 1);
      chk("flow_data", obs8(), model(8, 'h30 + r));
      if (in_valid && in_ready8) acc++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("flow_done", out_valid8, 0);

    // forwarded mode on an empty pipeline
    mode = 1'b1; in_valid = 1'b1; in_data8 = 8'h19;
    #1;
    chk("fwd_in_ready", in_ready8, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("fwd_valid", out_valid8, 1);
    chk("fwd_data", obs8(), pack(16'h19, 16'h26, 16'hB6, 1'b1));

    // mode drop while occupied keeps forwarded behaviour
    out_ready = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data8 = 8'h0A;
    #1;
    chk("fwd_stall_in_ready", in_ready8, 0);
    out_ready = 1'b1;
    #1;
    chk("fwd_release_in_ready", in_ready8, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("fwd_sticky_valid", out_valid8, 1);
    chk("fwd_sticky_data", obs8(), model(8, 'h0A));
    tick();
    chk("fwd_drained", out_valid8, 0);

    // mode raise while occupied keeps pipelined behaviour
    in_valid = 1'b1; in_data8 = 8'h0A;
    tick();
    mode = 1'b1; in_data8 = 8'hFA;
    tick();
    in_valid = 1'b0;
    #1;
    chk("pipe_sticky_latency", out_valid8, 0);
    tick();
    chk("pipe_sticky_a", obs8(), model(8, 'h0A));
    tick();
    chk("pipe_sticky_b_v", out_valid8, 1);
    chk("pipe_sticky_b", obs8(), model(8, 'hFA));
    tick();
    chk("pipe_sticky_drained", out_valid8, 0);

    // reset with three results in flight
    mode = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data8 = 8'(k + 1);
      tick();
    end
    #1;
    chk("rst_mid_full", out_valid8, 1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready8, 0);
    tick();
    #1;
    chk("rst_mid_valid", out_valid8, 0);
    chk("rst_mid_data", obs8(), 0);
    RST_N = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_no_stale", out_valid8, 0);
    end

    // randomized traffic against the scoreboards
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    q8.delete();
    q12.delete();
    prev_stall8 = 1'b0;
    prev_obs8 = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data8  = 8'($urandom);
      in_data12 = 12'($urandom);
      #1;
      sb_step();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      sb_step();
      tick();
    end
    chk("rnd8_drained", q8.size(), 0);
    chk("rnd12_drained", q12.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
